// File: rtl/definitions_pkg.sv
// Shared register-file definitions: the architectural register names.
package definitions;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [REG_IDX_W-1:0] {
    zero, ra, sp, gp, tp, t0, t1, t2,
    s0, s1, a0, a1, a2, a3, a4, a5,
    a6, a7, s2, s3, s4, s5, s6, s7,
    s8, s9, s10, s11, t3, t4, t5, t6
  } regName_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// Bundle of the writeback (MEM/WB) and decode read-port signals of the register file.
interface writeback_regfile_if;
  import definitions::*;

  logic                 regWrite_Wb_In;
  logic                 memToRegWrite_Wb_In;
  logic [XLEN-1:0]      readD_Wb_In;
  logic [XLEN-1:0]      aluOut_Wb_In;
  regName_t             rd_Wb_In;
  regName_t             rs1_Id_In;
  regName_t             rs2_Id_In;
  logic [XLEN-1:0]      rs1Data_Id_Out;
  logic [XLEN-1:0]      rs2Data_Id_Out;
  logic [XLEN-1:0]      wbData_Out;
  logic                 wbValid_Out;

  modport master (
    output regWrite_Wb_In, memToRegWrite_Wb_In, readD_Wb_In, aluOut_Wb_In,
           rd_Wb_In, rs1_Id_In, rs2_Id_In,
    input  rs1Data_Id_Out, rs2Data_Id_Out, wbData_Out, wbValid_Out
  );

  modport slave (
    input  regWrite_Wb_In, memToRegWrite_Wb_In, readD_Wb_In, aluOut_Wb_In,
           rd_Wb_In, rs1_Id_In, rs2_Id_In,
    output rs1Data_Id_Out, rs2Data_Id_Out, wbData_Out, wbValid_Out
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback-stage register file: x1..x31 storage, two combinational read ports.
// Optional macro REGFILE_BYPASS_EN enables write-first bypass on the read ports.
module writeback_regfile
  import definitions::*;
(
  input  logic                clk,
  input  logic                rstN,
  writeback_regfile_if.slave  bus
);

  logic [XLEN-1:0] regs [31:1];
  logic [XLEN-1:0] wb_data;
  logic            wb_valid;

  // Writeback mux and write qualifier; x0 writes never qualify.
  always_comb begin
    wb_data  = bus.memToRegWrite_Wb_In ? bus.readD_Wb_In : bus.aluOut_Wb_In;
    wb_valid = bus.regWrite_Wb_In && (bus.rd_Wb_In != zero);
  end

  assign bus.wbData_Out  = wb_data;
  assign bus.wbValid_Out = wb_valid;

  // Storage; async reset clears everything and drops any concurrent write.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[bus.rd_Wb_In] <= wb_data;
    end
  end

  // Read ports: x0 is hardwired to zero, optionally bypassing the in-flight write.
  always_comb begin
    bus.rs1Data_Id_Out = '0;
    bus.rs2Data_Id_Out = '0;
    if (bus.rs1_Id_In != zero) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_valid && (bus.rs1_Id_In == bus.rd_Wb_In)) begin
        bus.rs1Data_Id_Out = wb_data;
      end else begin
        bus.rs1Data_Id_Out = regs[bus.rs1_Id_In];
      end
`else
      bus.rs1Data_Id_Out = regs[bus.rs1_Id_In];
`endif
    end
    if (bus.rs2_Id_In != zero) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_valid && (bus.rs2_Id_In == bus.rd_Wb_In)) begin
        bus.rs2Data_Id_Out = wb_data;
      end else begin
        bus.rs2Data_Id_Out = regs[bus.rs2_Id_In];
      end
`else
      bus.rs2Data_Id_Out = regs[bus.rs2_Id_In];
`endif
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: vector table, directed corner cases, random vs array model.
module tb_writeback_regfile;
  import definitions::*;

  logic clk;
  logic rstN;
  writeback_regfile_if bus ();

  writeback_regfile dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [32];

  typedef struct {
    bit          we;
    bit          m2r;
    logic [31:0] ld;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_wb;
    bit          exp_valid;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit we, input bit m2r, input logic [31:0] ld, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.regWrite_Wb_In      = we;
    bus.memToRegWrite_Wb_In = m2r;
    bus.readD_Wb_In         = ld;
    bus.aluOut_Wb_In        = alu;
    bus.rd_Wb_In            = regName_t'(rd);
    bus.rs1_Id_In           = regName_t'(rs1);
    bus.rs2_Id_In           = regName_t'(rs2);
  endtask

  // Reference read: x0 is zero; the bypass build sees the pending write.
  function automatic logic [31:0] model_read(input logic [4:0] rs, input bit we, input bit m2r,
                                             input logic [31:0] ld, input logic [31:0] alu,
                                             input logic [4:0] rd);
    if (rs == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && rd != 5'd0 && rs == rd) return m2r ? ld : alu;
`endif
    return mem[rs];
  endfunction

  function automatic void model_write(input bit we, input bit m2r, input logic [31:0] ld,
                                      input logic [31:0] alu, input logic [4:0] rd);
    if (we && rd != 5'd0) mem[rd] = m2r ? ld : alu;
  endfunction

  // One model-checked cycle: drive at negedge, check pre-edge, clock, check post-edge.
  task automatic cycle(input bit we, input bit m2r, input logic [31:0] ld, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    drive(we, m2r, ld, alu, rd, rs1, rs2);
    #1;
    chk("rnd_wbdata", bus.wbData_Out, m2r ? ld : alu);
    chk("rnd_wbvalid", 32'(bus.wbValid_Out), 32'(we && rd != 5'd0));
    chk("rnd_rs1_pre", bus.rs1Data_Id_Out, model_read(rs1, we, m2r, ld, alu, rd));
    chk("rnd_rs2_pre", bus.rs2Data_Id_Out, model_read(rs2, we, m2r, ld, alu, rd));
    @(posedge clk);
    model_write(we, m2r, ld, alu, rd);
    #1;
    chk("rnd_rs1_post", bus.rs1Data_Id_Out, model_read(rs1, we, m2r, ld, alu, rd));
    chk("rnd_rs2_post", bus.rs2Data_Id_Out, model_read(rs2, we, m2r, ld, alu, rd));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    vecs[0] = '{1, 0, 32'h0,        32'h1234,     5'd3,  5'd3,  5'd3,  32'h1234,     1, 32'h1234,     32'h1234};
    vecs[1] = '{1, 1, 32'hCAFE0000, 32'h1,        5'd31, 5'd31, 5'd3,  32'hCAFE0000, 1, 32'hCAFE0000, 32'h1234};
    vecs[2] = '{1, 0, 32'h0,        32'hFFFFFFFF, 5'd0,  5'd0,  5'd31, 32'hFFFFFFFF, 0, 32'h0,        32'hCAFE0000};
    vecs[3] = '{0, 1, 32'hAAAA,     32'h55,       5'd9,  5'd9,  5'd3,  32'hAAAA,     0, 32'h0,        32'h1234};
    vecs[4] = '{0, 0, 32'h0,        32'h55,       5'd9,  5'd9,  5'd9,  32'h55,       0, 32'h0,        32'h0};
    vecs[5] = '{0, 0, 32'h0,        32'h55,       5'd9,  5'd9,  5'd9,  32'h55,       0, 32'h0,        32'h0};
    vecs[6] = '{1, 0, 32'h0,        32'h11,       5'd7,  5'd7,  5'd31, 32'h11,       1, 32'h11,       32'hCAFE0000};

    rstN = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd31);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rs1", bus.rs1Data_Id_Out, 32'h0);
    chk("reset_rs2", bus.rs2Data_Id_Out, 32'h0);

    // Write presented during reset must be lost.
    drive(1, 0, 32'h0, 32'h77, 5'd4, 5'd0, 5'd4);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
    #1;
    chk("reset_write_lost", bus.rs1Data_Id_Out, 32'h0);
    @(negedge clk);

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].we, vecs[i].m2r, vecs[i].ld, vecs[i].alu, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      #1;
      chk($sformatf("vec%0d_wbdata", i), bus.wbData_Out, vecs[i].exp_wb);
      chk($sformatf("vec%0d_wbvalid", i), 32'(bus.wbValid_Out), 32'(vecs[i].exp_valid));
      if (vecs[i].rs1 == 5'd0) chk($sformatf("vec%0d_zero_pre", i), bus.rs1Data_Id_Out, 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rs1", i), bus.rs1Data_Id_Out, vecs[i].exp_rs1);
      chk($sformatf("vec%0d_rs2", i), bus.rs2Data_Id_Out, vecs[i].exp_rs2);
      model_write(vecs[i].we, vecs[i].m2r, vecs[i].ld, vecs[i].alu, vecs[i].rd);
      @(negedge clk);
    end

    // Same-cycle read/write of x7 (holds 32'h11).
    drive(1, 0, 32'h0, 32'h22, 5'd7, 5'd7, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rw_pre", bus.rs1Data_Id_Out, 32'h22);
`else
    chk("rw_pre", bus.rs1Data_Id_Out, 32'h11);
`endif
    @(posedge clk);
    #1;
    chk("rw_post", bus.rs1Data_Id_Out, 32'h22);
    model_write(1, 0, 32'h0, 32'h22, 5'd7);
    @(negedge clk);

    // Random traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      logic [4:0] r1;
      logic [4:0] r2;
      rd = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      cycle(1'($urandom), 1'($urandom), $urandom, $urandom, rd, r1, r2);
    end

    // Reset mid-run: x5 written, then reset pulsed between edges.
    cycle(1, 0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    #1;
    chk("mid_before_rst", bus.rs1Data_Id_Out, 32'hDEADBEEF);
    #1;
    rstN = 1'b0;
    #1;
    chk("mid_rst_rs1", bus.rs1Data_Id_Out, 32'h0);
    chk("mid_rst_wbvalid", 32'(bus.wbValid_Out), 32'h0);
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    #1;
    rstN = 1'b1;
    @(negedge clk);
    // First write after reset lands on the first edge.
    drive(1, 1, 32'h66, 32'h1, 5'd6, 5'd6, 5'd5);
    @(posedge clk);
    #1;
    chk("post_rst_write", bus.rs1Data_Id_Out, 32'h66);
    chk("post_rst_x5", bus.rs2Data_Id_Out, 32'h0);
    model_write(1, 1, 32'h66, 32'h1, 5'd6);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
